id_ex_stage: RTL

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/id_ex_stage.sv | 134 +++++++++++++
 1 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with writeback bypass, load-use hazard stall and flush.
// Ports:
//   in  : clk, rst_n, id_* (decoded instruction), wb_* (writeback port), flush
//   out : stall (comb), ex_* (registered EX operands), stall_cnt, flush_cnt
module id_ex_stage #(
    parameter int CTRL_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic [4:0]        id_rd,
    input  logic [31:0]       id_rdata1,
    input  logic [31:0]       id_rdata2,
    input  logic [31:0]       id_imm,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              wb_regwrite,
    input  logic [4:0]        wb_reg,
    input  logic [31:0]       wb_data,
    input  logic              flush,
    output logic              stall,
    output logic              ex_valid,
    output logic [4:0]        ex_rs,
    output logic [4:0]        ex_rt,
    output logic [4:0]        ex_dst,
    output logic [31:0]       ex_a,
    output logic [31:0]       ex_b,
    output logic [31:0]       ex_imm,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [15:0]       stall_cnt,
    output logic [15:0]       flush_cnt
);

    typedef enum logic {
        RUN    = 1'b0,
        BUBBLE = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_valid;
    logic [4:0]        r_rs;
    logic [4:0]        r_rt;
    logic [4:0]        r_dst;
    logic [31:0]       r_a;
    logic [31:0]       r_b;
    logic [31:0]       r_imm;
    logic [CTRL_W-1:0] r_ctrl;
    logic [15:0]       r_stall_cnt;
    logic [15:0]       r_flush_cnt;

    logic              w_byp_a;
    logic              w_byp_b;
    logic [31:0]       w_op_a;
    logic [31:0]       w_op_b;
    logic              w_hz;
    logic              w_stall;

    // Writeback lands in the register file this same edge, so forward it.
    assign w_byp_a = wb_regwrite && (wb_reg != 5'd0) && (wb_reg == id_rs);
    assign w_byp_b = wb_regwrite && (wb_reg != 5'd0) && (wb_reg == id_rt);
    assign w_op_a  = w_byp_a ? wb_data : id_rdata1;
    assign w_op_b  = w_byp_b ? wb_data : id_rdata2;

    // Load in EX whose destination is read by the instruction in ID.
    assign w_hz = id_valid && r_valid && r_ctrl[1] && (r_dst != 5'd0) &&
                  ((r_dst == id_rs) || (r_dst == id_rt));

    assign w_stall = (r_state == RUN) && w_hz && !flush;
    assign stall   = w_stall;

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            RUN:     if (w_stall) w_state_nxt = BUBBLE;
            BUBBLE:  w_state_nxt = RUN;
            default: w_state_nxt = RUN;
        endcase
        if (flush) w_state_nxt = RUN;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid     <= 1'b0;
            r_rs        <= '0;
            r_rt        <= '0;
            r_dst       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_imm       <= '0;
            r_ctrl      <= '0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
            if (r_flush_cnt != 16'hFFFF) r_flush_cnt <= r_flush_cnt + 16'd1;
        end else if (w_stall) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
            if (r_stall_cnt != 16'hFFFF) r_stall_cnt <= r_stall_cnt + 16'd1;
        end else begin
            r_valid <= id_valid;
            r_ctrl  <= id_valid ? id_ctrl : '0;
            r_a     <= w_op_a;
            r_b     <= w_op_b;
            r_imm   <= id_imm;
            r_rs    <= id_rs;
            r_rt    <= id_rt;
            r_dst   <= id_ctrl[4] ? id_rd : id_rt;
        end
    end

    assign ex_valid  = r_valid;
    assign ex_rs     = r_rs;
    assign ex_rt     = r_rt;
    assign ex_dst    = r_dst;
    assign ex_a      = r_a;
    assign ex_b      = r_b;
    assign ex_imm    = r_imm;
    assign ex_ctrl   = r_ctrl;
    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

endmodule
